// File: rtl/an_encoder_seq.sv
// ---------------------------------------------------------------------------
// an_encoder_seq
//
// Purpose
//   Sequential AN-code encoder. It accepts one unsigned data word N and
//   produces the codeword W = A*N + e, reduced modulo 2^WW. The product is
//   built with a shift-add loop that walks the AW bits of the constant A, one
//   bit per clock. An optional single arithmetic-weight error e = +/-2^i can
//   be injected into the codeword. This lets the downstream single-error-
//   correcting AN decoder (which uses the same A) be exercised with known
//   faults.
//
//   Only one word is in flight at a time. A new word is accepted only in
//   IDLE. The finished codeword is held in DONE until the consumer takes it.
//
// Parameters
//   A   AN-code multiplier. Must match the decoder's A.
//   NW  data-word width.
//   AW  width of A. This is also the number of shift-add iterations.
//   WW  codeword width. Expected to be NW+AW.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_data (and the injection controls) are offered
//   in_ready   block accepts a word this cycle (IDLE only)
//   in_data    unsigned data word N
//   inj_en     inject an arithmetic-weight error into this word
//   inj_sign   error polarity: 0 = +2^i, 1 = -2^i
//   inj_pos    error exponent i (ignored when i >= WW)
//   out_valid  out_data holds a finished codeword
//   out_ready  downstream consumer takes out_data
//   out_data   codeword W = A*N + e mod 2^WW
//   busy       FSM is in CALC or DONE
// ---------------------------------------------------------------------------
module an_encoder_seq #(
  parameter int A  = 6311,
  parameter int NW = 20,
  parameter int AW = 13,
  parameter int WW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_data,
  input  logic          inj_en,
  input  logic          inj_sign,
  input  logic [5:0]    inj_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WW-1:0] out_data,
  output logic          busy
);

  // The iteration counter only has to index the bits of A, so clog2(AW)
  // bits are enough. It may step one past AW-1 on the final edge, but it is
  // reloaded on every accept, so that extra step is harmless.
  localparam int KW = (AW > 1) ? $clog2(AW) : 1;

  // A as a bit vector, so that the shift-add loop can test one bit per
  // iteration.
  localparam logic [AW-1:0] A_BITS = AW'(A);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [NW-1:0] n_q;
  logic          inj_en_q;
  logic          inj_sign_q;
  logic [5:0]    inj_pos_q;
  logic [WW-1:0] acc;
  logic [KW-1:0] k;

  logic          accept;
  logic          last_iter;
  logic [WW-1:0] n_wide;
  logic [WW-1:0] addend;
  logic [WW-1:0] acc_next;
  logic          inj_active;
  logic [WW-1:0] err_mag;
  logic [WW-1:0] coded;

  // A handshake completes only when the block is ready and the source offers
  // a word. in_ready already folds in rst, so reset wins over an accept that
  // would otherwise happen in the same cycle.
  assign accept    = in_valid && in_ready;
  assign last_iter = (k == KW'(AW - 1));

  // Shift-add datapath. Each CALC iteration adds N shifted by k, but only
  // when bit k of A is set. The sum is kept to WW bits, so everything is
  // already modulo 2^WW. The injected error is applied in the same cycle as
  // the last partial product. It is added or subtracted in WW-bit arithmetic,
  // which gives the required wrap-around with no saturation. An exponent
  // that falls outside the codeword disables the injection entirely.
  always_comb begin
    n_wide     = WW'(n_q);
    addend     = A_BITS[k] ? (n_wide << k) : '0;
    acc_next   = acc + addend;
    inj_active = inj_en_q && (int'(inj_pos_q) < WW);
    err_mag    = inj_active ? (WW'(1) << inj_pos_q) : '0;
    coded      = inj_sign_q ? (acc_next - err_mag) : (acc_next + err_mag);
  end

  // State register. Reset is synchronous and drops straight back to IDLE,
  // throwing away any word that is being computed or waiting in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. CALC runs for exactly AW edges. The edge on which
  // k == AW-1 also loads the codeword and moves to DONE. DONE waits as long
  // as needed for the consumer. Leaving DONE always goes through IDLE, so
  // back-to-back words cost AW+2 cycles each.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status outputs, decoded from the current state.
  // in_ready is also forced low while rst is high, so no source can see a
  // ready that the reset is about to override.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
      end
      CALC: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Word latches, accumulator, iteration counter and output register.
  // Everything the computation uses is captured only on the accept edge, so
  // later changes on the inputs cannot disturb the word in flight. out_data
  // is written only on the final CALC edge. It therefore stays stable through
  // DONE and keeps the last codeword after the handover.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      inj_en_q   <= 1'b0;
      inj_sign_q <= 1'b0;
      inj_pos_q  <= '0;
      acc        <= '0;
      k          <= '0;
      out_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            n_q        <= in_data;
            inj_en_q   <= inj_en;
            inj_sign_q <= inj_sign;
            inj_pos_q  <= inj_pos;
            acc        <= '0;
            k          <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          k   <= k + KW'(1);
          if (last_iter) begin
            out_data <= coded;
          end
        end
        DONE: begin
          acc <= acc;
        end
        default: begin
          acc <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/an_encoder_seq.md
AN_ENCODER_SEQ -- requirements
Module: an_encoder_seq

Interface
REQ-001 Parameter A, default 6311, meaning AN-code multiplier; identical to the downstream SEC decoder's A.
REQ-002 Parameter NW, default 20, meaning data-word width.
REQ-003 Parameter AW, default 13, meaning width of A; the shift-add iteration count.
REQ-004 Parameter WW, default 33, meaning codeword width (NW+AW).
REQ-005 Port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, meaning reset; synchronous, active-high.
REQ-007 Port in_valid, input, 1, meaning in_data is offered.
REQ-008 Port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-009 Port in_data, input, NW, meaning unsigned data word N.
REQ-010 Port inj_en, input, 1, meaning inject a single arithmetic-weight error into this word; sampled with in_data.
REQ-011 Port inj_sign, input, 1, meaning error polarity: 0 = +2^i, 1 = -2^i.
REQ-012 Port inj_pos, input, 6, meaning error exponent i.
REQ-013 Port out_valid, output, 1, meaning out_data holds a finished codeword.
REQ-014 Port out_ready, input, 1, meaning the downstream consumer takes out_data.
REQ-015 Port out_data, output, WW, meaning codeword W = A*N + e, unsigned.
REQ-016 Port busy, output, 1, meaning the FSM is not IDLE.

Function
REQ-017 FSM states are IDLE, CALC and DONE; the block holds exactly one word in flight.
REQ-018 in_ready SHALL be 1 only in IDLE; accept occurs on an edge where in_valid and in_ready are both 1.
REQ-019 On accept: latch N, inj_en, inj_sign and inj_pos; clear the accumulator; set iteration counter k=0; go to CALC.
REQ-020 In CALC, each edge: acc <= acc + (A[k] ? (N << k) : 0), widths WW; k <= k+1.
REQ-021 CALC lasts exactly AW edges (k = 0..AW-1); on the edge with k = AW-1, go to DONE and load out_data.
REQ-022 The loaded out_data is (final acc + signed error) mod 2^WW.
REQ-023 The error is 0 unless the latched inj_en = 1 and inj_pos <= WW-1.
REQ-024 With inj_pos >= WW, the injection is ignored and the word is encoded clean.
REQ-025 Negative injection below zero, or positive injection above 2^WW-1, SHALL wrap modulo 2^WW; no saturation and no flag.
REQ-026 Latency: out_valid first reads 1 in the cycle after the AW-th edge following the accept edge (13 cycles for the default).
REQ-027 In DONE, out_valid = 1, and out_data is held stable while out_ready = 0, for any number of cycles.
REQ-028 In DONE with out_ready = 1, go to IDLE at that edge; out_valid drops and in_ready rises the next cycle.
REQ-029 Because of REQ-028, back-to-back throughput is one word per AW+2 cycles.
REQ-030 out_data SHALL retain the last codeword after handover; it is don't-care while out_valid = 0.
REQ-031 Input changes outside the accept edge SHALL NOT affect the word in flight.
REQ-032 busy = 1 in CALC and DONE.

Reset
REQ-033 With rst = 1 at an edge, the block enters IDLE, and out_valid=0, out_data=0, busy=0, acc=0, k=0, injection latches=0.
REQ-034 in_ready SHALL read 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-035 rst SHALL take priority over every handshake in the same cycle.
REQ-036 Reset during CALC or DONE SHALL discard the in-flight word; no out_valid pulse follows.

Verification
REQ-037 N=1, inj_en=0, out_ready=1 -> out_valid 13 cycles after accept, out_data=6311; N=1048575 -> out_data=6617556825.
REQ-038 N=5, inj_en=1, inj_sign=0, inj_pos=13 -> out_data=39747; downstream decoder returns N=5 (residue 1881).
REQ-039 N=0, inj_en=1, inj_sign=1, inj_pos=0 -> out_data=8589934591 (wrap); N=7, inj_pos=40 -> out_data=44177 (ignored).
REQ-040 out_ready held 0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; handover on first out_ready=1; next accept no earlier than 1 cycle later.
REQ-041 Stress: 1000 random N with random injections, random in_valid/out_ready gaps -> every out_data equals the golden A*N±2^i mod 2^33, in order, with no loss or duplication.
REQ-042 rst asserted at CALC k=6, with in_valid held high -> IDLE next cycle, no out_valid; the next accepted N=3 yields 18933.
